// File: rtl/hazard_scoreboard_pkg.sv
// Shared latency-class encodings and helpers for the hazard scoreboard.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'b00,
    LAT_LOAD = 2'b01,
    LAT_MUL  = 2'b10,
    LAT_RSVD = 2'b11
  } lat_class_e;

  localparam int REG_IDX_W = 5;

  // Cycles from issue until the result is forwardable; the reserved class behaves as ALU.
  function automatic int lat_of(input logic [1:0] cls, input int mul_lat);
    case (lat_class_e'(cls))
      LAT_LOAD: return 1;
      LAT_MUL:  return mul_lat;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side issue request and scoreboard stall response bundle.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG = 32
) ();
  logic                 issue_valid;
  logic                 rs1_used;
  logic                 rs2_used;
  logic [REG_IDX_W-1:0] rs1_d;
  logic [REG_IDX_W-1:0] rs2_d;
  logic [REG_IDX_W-1:0] rd_d;
  logic [1:0]           lat_class;
  logic                 flush_ex;
  logic                 stall;
  logic                 issue_fire;
  logic [NREG-1:0]      pending_mask;

  modport master (
    output issue_valid, rs1_used, rs2_used, rs1_d, rs2_d, rd_d, lat_class, flush_ex,
    input  stall, issue_fire, pending_mask
  );

  modport slave (
    input  issue_valid, rs1_used, rs2_used, rs1_d, rs2_d, rd_d, lat_class, flush_ex,
    output stall, issue_fire, pending_mask
  );
endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's countdown until its in-flight result becomes forwardable.
module sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // A new issue beats a flush of the older writer to the same register.
  always_ff @(posedge i_clk) begin
    if (i_rst)               r_cnt <= '0;
    else if (i_load)         r_cnt <= i_load_val;
    else if (i_clr)          r_cnt <= '0;
    else if (r_cnt != '0)    r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers and raises a decode stall on RAW/WAW hazards.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  hazard_scoreboard_if.slave bus
);
  logic [NREG-1:0][CNT_W-1:0] w_cnt;
  logic [NREG-1:0]            w_pend;
  logic [CNT_W-1:0]           w_lat;
  logic                       w_raw1;
  logic                       w_raw2;
  logic                       w_waw;
  logic                       w_stall;
  logic                       w_fire;
  logic [REG_IDX_W-1:0]       r_last_rd;
  logic                       r_last_vld;

  assign w_lat = CNT_W'(lat_of(bus.lat_class, MUL_LAT));

  // x0 has no entry; its count reads as zero so it never stalls.
  assign w_cnt[0]  = '0;
  assign w_pend[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_ent
    sb_entry #(.CNT_W(CNT_W)) u_ent (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_fire && (bus.rd_d == REG_IDX_W'(g))),
      .i_load_val (w_lat),
      .i_clr      (bus.flush_ex && r_last_vld && (r_last_rd == REG_IDX_W'(g))),
      .o_cnt      (w_cnt[g])
    );
    assign w_pend[g] = |w_cnt[g];
  end

  assign w_raw1  = bus.rs1_used && (bus.rs1_d != '0) && (w_cnt[bus.rs1_d] != '0);
  assign w_raw2  = bus.rs2_used && (bus.rs2_d != '0) && (w_cnt[bus.rs2_d] != '0);
  // An older write still landing after this one would clobber the younger result.
  assign w_waw   = (bus.rd_d != '0) && (w_cnt[bus.rd_d] > w_lat);
  assign w_stall = bus.issue_valid && (w_raw1 || w_raw2 || w_waw);
  assign w_fire  = bus.issue_valid && !w_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_vld <= 1'b0;
      r_last_rd  <= '0;
    end else begin
      r_last_vld <= w_fire && (bus.rd_d != '0);
      if (w_fire) r_last_rd <= bus.rd_d;
    end
  end

  assign bus.stall        = w_stall;
  assign bus.issue_fire   = w_fire;
  assign bus.pending_mask = w_pend;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus random traffic checked against a behavioural scoreboard model.
module tb_hazard_scoreboard;
  localparam int NREG    = 32;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NREG)) bus ();

  hazard_scoreboard #(.NREG(NREG), .MUL_LAT(MUL_LAT), .CNT_W(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: remaining cycles per register, plus the register written by last cycle's issue.
  int m_cnt[NREG];
  int m_last_rd = 0;
  bit m_last_vld = 1'b0;

  logic            o_stall, o_fire;
  logic [NREG-1:0] o_pm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat_m(input int cls);
    if (cls == 1) return 1;
    if (cls == 2) return MUL_LAT;
    return 0;
  endfunction

  // Compare DUT to model mid-cycle, then advance the model to the next edge.
  initial begin
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        int  lat, r1, r2, rd;
        bit  e_stall, e_fire;
        logic [NREG-1:0] e_pm;
        r1  = int'(bus.rs1_d);
        r2  = int'(bus.rs2_d);
        rd  = int'(bus.rd_d);
        lat = lat_m(int'(bus.lat_class));
        e_stall = bus.issue_valid &&
                  ((bus.rs1_used && r1 != 0 && m_cnt[r1] > 0) ||
                   (bus.rs2_used && r2 != 0 && m_cnt[r2] > 0) ||
                   (rd != 0 && m_cnt[rd] > lat));
        e_fire = bus.issue_valid && !e_stall;
        e_pm = '0;
        for (int r = 1; r < NREG; r++) e_pm[r] = (m_cnt[r] > 0);
        check("stall", 32'(bus.stall), 32'(e_stall));
        check("issue_fire", 32'(bus.issue_fire), 32'(e_fire));
        check("pending_mask", bus.pending_mask, e_pm);
        if (rst) begin
          for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
          m_last_rd = 0;
          m_last_vld = 1'b0;
        end else begin
          bit flush_hit;
          int flush_rd;
          flush_hit = bus.flush_ex && m_last_vld;
          flush_rd  = m_last_rd;
          for (int r = 0; r < NREG; r++) if (m_cnt[r] > 0) m_cnt[r]--;
          if (flush_hit) m_cnt[flush_rd] = 0;
          if (e_fire && rd != 0) m_cnt[rd] = lat;
          m_last_vld = e_fire && rd != 0;
          if (e_fire) m_last_rd = rd;
        end
      end
    end
  end

  task automatic cyc(input logic iv, input logic u1, input logic u2,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic [1:0] cls, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    bus.issue_valid = iv;
    bus.rs1_used    = u1;
    bus.rs2_used    = u2;
    bus.rs1_d       = r1;
    bus.rs2_d       = r2;
    bus.rd_d        = rd;
    bus.lat_class   = cls;
    bus.flush_ex    = fl;
    rst             = rs;
    #2;
    o_stall = bus.stall;
    o_fire  = bus.issue_fire;
    o_pm    = bus.pending_mask;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    bus.issue_valid = 0; bus.rs1_used = 0; bus.rs2_used = 0;
    bus.rs1_d = 0; bus.rs2_d = 0; bus.rd_d = 0; bus.lat_class = 0; bus.flush_ex = 0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    check("reset_stall", 32'(o_stall), 32'd0);
    check("reset_pm", o_pm, 32'd0);
    idle(1);

    // Load-use
    cyc(1, 0, 0, 0, 0, 5, 2'b01, 0, 0);
    cyc(1, 1, 0, 5, 0, 7, 2'b00, 0, 0);
    check("loaduse_stall", 32'(o_stall), 32'd1);
    check("loaduse_pm5", 32'(o_pm[5]), 32'd1);
    cyc(1, 1, 0, 5, 0, 7, 2'b00, 0, 0);
    check("loaduse_fire", 32'(o_fire), 32'd1);
    idle(4);

    // ALU-ALU back to back
    cyc(1, 0, 0, 0, 0, 7, 2'b00, 0, 0);
    cyc(1, 0, 1, 0, 7, 8, 2'b00, 0, 0);
    check("aluchain_fire", 32'(o_fire), 32'd1);
    idle(4);

    // MUL chain: three stall cycles
    cyc(1, 0, 0, 0, 0, 3, 2'b10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 3, 0, 6, 2'b00, 0, 0);
      check("mul_stall", 32'(o_stall), 32'd1);
      check("mul_pm3", 32'(o_pm[3]), 32'd1);
    end
    cyc(1, 1, 0, 3, 0, 6, 2'b00, 0, 0);
    check("mul_fire", 32'(o_fire), 32'd1);
    check("mul_pm3_clear", 32'(o_pm[3]), 32'd0);
    idle(4);

    // WAW: ALU writer waits for cnt 0, LOAD writer only while cnt > 1
    cyc(1, 0, 0, 0, 0, 4, 2'b10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 4, 2'b00, 0, 0);
      check("waw_alu_stall", 32'(o_stall), 32'd1);
    end
    cyc(1, 0, 0, 0, 0, 4, 2'b00, 0, 0);
    check("waw_alu_fire", 32'(o_fire), 32'd1);
    idle(4);
    cyc(1, 0, 0, 0, 0, 4, 2'b10, 0, 0);
    cyc(1, 0, 0, 0, 0, 4, 2'b01, 0, 0);
    check("waw_ld_stall3", 32'(o_stall), 32'd1);
    cyc(1, 0, 0, 0, 0, 4, 2'b01, 0, 0);
    check("waw_ld_stall2", 32'(o_stall), 32'd1);
    cyc(1, 0, 0, 0, 0, 4, 2'b01, 0, 0);
    check("waw_ld_fire1", 32'(o_fire), 32'd1);
    idle(4);

    // Flush of the last issue
    cyc(1, 0, 0, 0, 0, 9, 2'b01, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    cyc(1, 1, 0, 9, 0, 10, 2'b00, 0, 0);
    check("flush_ld_fire", 32'(o_fire), 32'd1);
    check("flush_ld_pm9", 32'(o_pm[9]), 32'd0);
    idle(4);
    cyc(1, 0, 0, 0, 0, 9, 2'b10, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    cyc(1, 1, 0, 9, 0, 10, 2'b00, 0, 0);
    check("flush_mul_fire", 32'(o_fire), 32'd1);
    check("flush_mul_pm9", 32'(o_pm[9]), 32'd0);
    idle(4);

    // x0 never tracked; reset drops pending entries
    cyc(1, 0, 0, 0, 0, 0, 2'b01, 0, 0);
    cyc(1, 1, 0, 0, 0, 11, 2'b00, 0, 0);
    check("x0_fire", 32'(o_fire), 32'd1);
    idle(2);
    cyc(1, 0, 0, 0, 0, 2, 2'b10, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    check("rst_pm_before", 32'(o_pm[2]), 32'd1);
    cyc(1, 1, 0, 2, 0, 12, 2'b00, 0, 0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_pm", o_pm, 32'd0);
    idle(2);

    // Random traffic on a few registers to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      cyc(logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)),
          logic'($urandom_range(0, 5) == 0),
          logic'($urandom_range(0, 79) == 0));
    end
    idle(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
